ham_accum: RTL

Sequential accumulator that sits directly downstream of the 32-bit Hamming-weight unit in the ALU datapath. It consumes one 6-bit per-word population count per accepted beat and sums a programmed number of words into a block-level bit count. It also tracks the largest per-word count and flags out-of-range inputs. It serves multi-word popcount operations issued by the control unit and returns its result to the ALU result mux.

---
 rtl/ham_accum_if.sv | 27 ++
 rtl/ham_accum.sv | 91 +++++++++
 2 files changed

// File: rtl/ham_accum_if.sv
// Handshake/result bundle between the control unit and the Hamming-weight accumulator.
// The master drives the requests and the slave returns the block results.
interface ham_accum_if #(
  parameter int LEN_W = 8,
  parameter int SUM_W = LEN_W + 6
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [5:0]       hw;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum;
  logic [5:0]       max_hw;
  logic             err;

  modport master (
    output start, len, hw, in_valid,
    input  in_ready, busy, done, sum, max_hw, err
  );

  modport slave (
    input  start, len, hw, in_valid,
    output in_ready, busy, done, sum, max_hw, err
  );
endinterface

// File: rtl/ham_accum.sv
// Block-level popcount accumulator: sums a programmed number of per-word Hamming
// weights, tracks the largest weight and flags weights above 32.
module ham_accum #(
  parameter int LEN_W = 8,
  parameter int SUM_W = LEN_W + 6
) (
  input  logic        clk,
  input  logic        rst,
  ham_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] HW_LIMIT = 6'd32;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] rem;
  logic [SUM_W-1:0] sum;
  logic [5:0]       max_hw;
  logic             err;
  logic             done;

  logic             start_ok;
  logic             accept;
  logic [SUM_W-1:0] hw_ext;

  assign start_ok = (state == IDLE) && bus.start;
  assign accept   = (state == RUN) && bus.in_valid;
  assign hw_ext   = {{(SUM_W-6){1'b0}}, bus.hw};

  // NOTE: every variable gets its default before the case so no path leaves it
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.in_valid && (rem == LEN_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      sum    <= '0;
      max_hw <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == DONE);
      if (start_ok) begin
        rem    <= bus.len;
        sum    <= '0;
        max_hw <= '0;
        err    <= 1'b0;
      end else if (accept) begin
        // Out-of-range weights are still summed; err only marks them.
        rem    <= rem - LEN_W'(1);
        sum    <= sum + hw_ext;
        max_hw <= (bus.hw > max_hw) ? bus.hw : max_hw;
        err    <= err | (bus.hw > HW_LIMIT);
      end
    end
  end

  assign bus.in_ready = (state == RUN);
  assign bus.busy     = (state == RUN);
  assign bus.done     = done;
  assign bus.sum      = sum;
  assign bus.max_hw   = max_hw;
  assign bus.err      = err;

endmodule
